// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : PC-register, instruction-memory and issue signals between the
//            fetch sequencer and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             stall;
  logic             jumpEn;
  logic [WIDTH-1:0] jumpAddr;
  logic             endOp;
  logic [WIDTH-1:0] pcIn;
  logic             pcWrEn;
  logic             pcIncEn;
  logic [WIDTH-1:0] pcDataOut;
  logic             imemRdEn;
  logic [WIDTH-1:0] imemAddr;
  logic             instrValid;

  modport master (
    input  stall, jumpEn, jumpAddr, endOp, pcIn,
    output pcWrEn, pcIncEn, pcDataOut, imemRdEn, imemAddr, instrValid
  );

  modport slave (
    output stall, jumpEn, jumpAddr, endOp, pcIn,
    input  pcWrEn, pcIncEn, pcDataOut, imemRdEn, imemAddr, instrValid
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Sequences PC load/increment/jump and instruction-memory reads,
//            presenting each word to decode after a fixed memory latency.
//            Optional macro FETCH_INSTR_COUNT_EN adds the instrCount output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int               WIDTH       = 12,
  parameter int               MEM_LATENCY = 2,
  parameter logic [WIDTH-1:0] START_ADDR  = '0
) (
  input  wire logic        clk,
  input  wire logic        rstN,
  input  wire logic        start,
  output logic             busy,
  output logic             done,
`ifdef FETCH_INSTR_COUNT_EN
  output logic [15:0]      instrCount,
`endif
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_ISSUE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // WAIT lasts MEM_LATENCY-1 cycles, so the counter starts at MEM_LATENCY-2.
  localparam logic [1:0] c_WAIT_LOAD = (MEM_LATENCY >= 2) ? 2'(MEM_LATENCY - 2) : 2'd0;

  state_t     r_state;
  logic [1:0] r_waitCnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_LOAD;
        S_LOAD:  r_state <= S_FETCH;
        S_FETCH: begin
          if (MEM_LATENCY == 1) begin
            r_state <= S_ISSUE;
          end else begin
            r_waitCnt <= c_WAIT_LOAD;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_waitCnt == 2'd0) r_state <= S_ISSUE;
          else                   r_waitCnt <= r_waitCnt - 2'd1;
        end
        S_ISSUE: begin
          if (bus.endOp)      r_state <= S_DONE;
          else if (!bus.stall) r_state <= S_FETCH;
        end
        S_DONE:  if (start) r_state <= S_LOAD;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pcWrEn     = 1'b0;
    bus.pcIncEn    = 1'b0;
    bus.pcDataOut  = '0;
    bus.imemRdEn   = 1'b0;
    bus.imemAddr   = '0;
    bus.instrValid = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_LOAD: begin
        busy          = 1'b1;
        bus.pcWrEn    = 1'b1;
        bus.pcDataOut = START_ADDR;
      end
      S_FETCH: begin
        busy         = 1'b1;
        bus.imemRdEn = 1'b1;
        bus.imemAddr = bus.pcIn;
      end
      S_WAIT: begin
        busy         = 1'b1;
        bus.imemAddr = bus.pcIn;
      end
      S_ISSUE: begin
        busy           = 1'b1;
        bus.instrValid = 1'b1;
        bus.imemAddr   = bus.pcIn;
        // endOp outranks stall, which outranks the jump/increment choice.
        if (!bus.endOp && !bus.stall) begin
          if (bus.jumpEn) begin
            bus.pcWrEn    = 1'b1;
            bus.pcDataOut = bus.jumpAddr;
          end else begin
            bus.pcIncEn = 1'b1;
          end
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instrCount;
  logic        w_issueLeaves;
  logic        w_startAccepted;

  assign w_issueLeaves   = (r_state == S_ISSUE) && (bus.endOp || !bus.stall);
  assign w_startAccepted = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign instrCount      = r_instrCount;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_instrCount <= 16'd0;
    end else if (w_startAccepted) begin
      r_instrCount <= 16'd0;
    end else if (w_issueLeaves && (r_instrCount != 16'hFFFF)) begin
      r_instrCount <= r_instrCount + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer with a behavioural PC
//            register and a fetch-address / instrValid-timing scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;
  localparam int WIDTH = 12;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic rstN  = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] instrCount;
`endif

  fetch_sequencer_if #(.WIDTH(WIDTH)) bus ();

  fetch_sequencer #(
    .WIDTH       (WIDTH),
    .MEM_LATENCY (LAT),
    .START_ADDR  (12'h000)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .start      (start),
    .busy       (busy),
    .done       (done),
`ifdef FETCH_INSTR_COUNT_EN
    .instrCount (instrCount),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Behavioural incRegister holding the PC
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)            bus.pcIn <= '0;
    else if (bus.pcWrEn)  bus.pcIn <= bus.pcDataOut;
    else if (bus.pcIncEn) bus.pcIn <= bus.pcIn + 12'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [11:0] expAddrQ[$];
  int          validDueQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [29:0] outs();
    return {bus.pcWrEn, bus.pcIncEn, bus.pcDataOut, bus.imemRdEn, bus.imemAddr,
            bus.instrValid, busy, done};
  endfunction

  // Scoreboard monitor: fetch addresses and instrValid latency
  logic prevValid = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rstN) begin
      prevValid = 1'b0;
    end else begin
      if (bus.imemRdEn) begin
        if (expAddrQ.size() == 0) chk("fetch_unexpected", 32'(bus.imemAddr), 32'hFFFF_FFFF);
        else                      chk("fetch_addr", 32'(bus.imemAddr), 32'(expAddrQ.pop_front()));
        validDueQ.push_back(cyc + LAT);
      end
      if (bus.instrValid && !prevValid) begin
        if (validDueQ.size() == 0) chk("valid_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                       chk("valid_cycle", 32'(cyc), 32'(validDueQ.pop_front()));
      end
      prevValid = bus.instrValid;
      if (bus.pcWrEn || bus.pcIncEn) chk("strobe_excl", 32'(bus.pcWrEn & bus.pcIncEn), 32'd0);
      if (!bus.pcWrEn) chk("pcdata_zero", 32'(bus.pcDataOut), 32'd0);
    end
  end

  typedef struct {
    logic        st, sl, jm, en;
    logic [11:0] ja;
    logic [29:0] exp;
  } vec_t;

  function automatic vec_t V(input logic st, sl, jm, en, input logic [11:0] ja,
                             input logic wr, inc, input logic [11:0] pd,
                             input logic rd, input logic [11:0] ad,
                             input logic va, bu, dn);
    vec_t r;
    r.st = st; r.sl = sl; r.jm = jm; r.en = en; r.ja = ja;
    r.exp = {wr, inc, pd, rd, ad, va, bu, dn};
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    start = 1'b0; bus.stall = 1'b0; bus.jumpEn = 1'b0; bus.endOp = 1'b0;
    #1;
  endtask

  task automatic waitValid(input string name);
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.instrValid) break;
    end
    chk(name, 32'(bus.instrValid), 32'd1);
  endtask

  vec_t tbl[29];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.stall = 1'b0; bus.jumpEn = 1'b0; bus.endOp = 1'b0; bus.jumpAddr = '0;

    //          st sl jm en ja       wr inc pd      rd ad      va bu dn
    tbl[0]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
    tbl[1]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
    tbl[2]  = V(1, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
    tbl[3]  = V(0, 0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 12'h000, 0, 1, 0);
    tbl[4]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h000, 0, 1, 0);
    tbl[5]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 1, 0);
    tbl[6]  = V(0, 0, 0, 0, 12'h000, 0, 1, 12'h000, 0, 12'h000, 1, 1, 0);
    tbl[7]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h001, 0, 1, 0);
    tbl[8]  = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h001, 0, 1, 0);
    tbl[9]  = V(0, 0, 0, 0, 12'h000, 0, 1, 12'h000, 0, 12'h001, 1, 1, 0);
    tbl[10] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h002, 0, 1, 0);
    tbl[11] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h002, 0, 1, 0);
    tbl[12] = V(0, 0, 0, 0, 12'h000, 0, 1, 12'h000, 0, 12'h002, 1, 1, 0);
    tbl[13] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h003, 0, 1, 0);
    tbl[14] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h003, 0, 1, 0);
    tbl[15] = V(0, 0, 1, 0, 12'h0A0, 1, 0, 12'h0A0, 0, 12'h003, 1, 1, 0);
    tbl[16] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h0A0, 0, 1, 0);
    tbl[17] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h0A0, 0, 1, 0);
    tbl[18] = V(0, 1, 1, 0, 12'h010, 0, 0, 12'h000, 0, 12'h0A0, 1, 1, 0);
    tbl[19] = V(0, 1, 1, 0, 12'h010, 0, 0, 12'h000, 0, 12'h0A0, 1, 1, 0);
    tbl[20] = V(0, 1, 1, 0, 12'h010, 0, 0, 12'h000, 0, 12'h0A0, 1, 1, 0);
    tbl[21] = V(0, 0, 1, 0, 12'h010, 1, 0, 12'h010, 0, 12'h0A0, 1, 1, 0);
    tbl[22] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h010, 0, 1, 0);
    tbl[23] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h010, 0, 1, 0);
    tbl[24] = V(0, 0, 1, 1, 12'h055, 0, 0, 12'h000, 0, 12'h010, 1, 1, 0);
    tbl[25] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    tbl[26] = V(1, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1);
    tbl[27] = V(0, 0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 12'h000, 0, 1, 0);
    tbl[28] = V(0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 12'h000, 0, 1, 0);

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("reset_outs%0d", i), 32'(outs()), 32'd0);
    end
    rstN = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      start = tbl[i].st; bus.stall = tbl[i].sl; bus.jumpEn = tbl[i].jm;
      bus.endOp = tbl[i].en; bus.jumpAddr = tbl[i].ja;
      if (tbl[i].exp[15]) expAddrQ.push_back(tbl[i].exp[14:3]);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
`ifdef FETCH_INSTR_COUNT_EN
      if (i == 25 || i == 26) chk("count_done", 32'(instrCount), 32'd6);
      if (i == 27)            chk("count_restart", 32'(instrCount), 32'd0);
`endif
    end

    // Jump to the top address, then let the PC register wrap
    waitValid("wrap_issue0");
    bus.jumpEn = 1'b1; bus.jumpAddr = 12'hFFF;
    expAddrQ.push_back(12'hFFF);
    #1;
    chk("jump_fff", 32'({bus.pcWrEn, bus.pcDataOut}), 32'({1'b1, 12'hFFF}));
    waitValid("wrap_issue1");
    chk("wrap_inc", 32'({bus.pcWrEn, bus.pcIncEn, bus.imemAddr}), 32'({1'b0, 1'b1, 12'hFFF}));
    expAddrQ.push_back(12'h000);
    step();
    chk("wrap_fetch", 32'({bus.imemRdEn, bus.imemAddr}), 32'({1'b1, 12'h000}));

    // Asynchronous reset asserted while waiting on memory
    @(negedge clk); #1;
    chk("in_wait", 32'({busy, bus.imemRdEn, bus.instrValid}), 32'(3'b100));
    rstN = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs()), 32'd0);
    validDueQ.delete();
    step();
    step();
    rstN = 1'b1;
    step();
    chk("idle_after_reset", 32'(outs()), 32'd0);
    step();
    chk("idle_holds", 32'(outs()), 32'd0);

    @(negedge clk);
    start = 1'b1;
    #1;
    step();
    chk("restart_load", 32'({bus.pcWrEn, bus.pcDataOut, busy}), 32'({1'b1, 12'h000, 1'b1}));
    expAddrQ.push_back(12'h000);
    step();
    waitValid("restart_issue");
    step();
    chk("addr_queue_drained", 32'(expAddrQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
